// File: rtl/rvfi_dmem_multi_check.sv
// Byte-granular shadow checker for RVFI data-memory traffic on a set of tracked words.
// Flags any read of a previously written byte that disagrees with the shadow copy.
module rvfi_dmem_multi_check #(
  parameter int XLEN  = 32,
  parameter int NRET  = 1,
  parameter int NADDR = 4,
  parameter int CNTW  = 16,
  localparam int NB = XLEN / 8,
  localparam int BW = $clog2(NB),
  localparam int CW = (NRET > 1) ? $clog2(NRET) : 1,
  localparam int SW = (NADDR > 1) ? $clog2(NADDR) : 1
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  enable,
  input  logic [NADDR*XLEN-1:0] track_addr,
  input  logic [NRET-1:0]       rvfi_valid,
  input  logic [NRET*XLEN-1:0]  rvfi_mem_addr,
  input  logic [NRET*NB-1:0]    rvfi_mem_rmask,
  input  logic [NRET*NB-1:0]    rvfi_mem_wmask,
  input  logic [NRET*XLEN-1:0]  rvfi_mem_rdata,
  input  logic [NRET*XLEN-1:0]  rvfi_mem_wdata,
  output logic                  mismatch,
  output logic                  err_sticky,
  output logic [CNTW-1:0]       err_count,
  output logic [CW-1:0]         err_chan,
  output logic [SW-1:0]         err_slot,
  output logic [BW-1:0]         err_byte
);

  logic [XLEN-BW-1:0] slot_word [NADDR];
  logic [XLEN-BW-1:0] chan_word [NRET];
  logic [NADDR*BW-1:0] unused_track_low;
  logic [NRET*BW-1:0]  unused_addr_low;

  genvar gi;
  generate
    for (gi = 0; gi < NADDR; gi++) begin : g_slot
      assign slot_word[gi] = track_addr[gi*XLEN+BW +: XLEN-BW];
      assign unused_track_low[gi*BW +: BW] = track_addr[gi*XLEN +: BW];
    end
    for (gi = 0; gi < NRET; gi++) begin : g_chan
      assign chan_word[gi] = rvfi_mem_addr[gi*XLEN+BW +: XLEN-BW];
      assign unused_addr_low[gi*BW +: BW] = rvfi_mem_addr[gi*XLEN +: BW];
    end
  endgenerate

  logic [XLEN-1:0] shadow_reg  [NADDR];
  logic [XLEN-1:0] shadow_next [NADDR];
  logic [NB-1:0]   written_reg  [NADDR];
  logic [NB-1:0]   written_next [NADDR];

  logic          fail_any;
  logic          cap_found;
  logic [CW-1:0] cap_chan;
  logic [SW-1:0] cap_slot;
  logic [BW-1:0] cap_byte;

  // The *_next arrays double as running state so that later channels observe
  // earlier channels' writes, while each lane compares before it updates.
  always_comb begin
    for (int k = 0; k < NADDR; k++) begin
      shadow_next[k]  = shadow_reg[k];
      written_next[k] = written_reg[k];
    end
    fail_any  = 1'b0;
    cap_found = 1'b0;
    cap_chan  = '0;
    cap_slot  = '0;
    cap_byte  = '0;
    for (int c = 0; c < NRET; c++) begin
      for (int k = 0; k < NADDR; k++) begin
        if (rvfi_valid[c] && (chan_word[c] == slot_word[k])) begin
          for (int i = 0; i < NB; i++) begin
            if (enable && rvfi_mem_rmask[c*NB+i] && written_next[k][i] &&
                (rvfi_mem_rdata[c*XLEN+8*i +: 8] != shadow_next[k][8*i +: 8])) begin
              fail_any = 1'b1;
              if (!cap_found) begin
                cap_found = 1'b1;
                cap_chan  = CW'(c);
                cap_slot  = SW'(k);
                cap_byte  = BW'(i);
              end
            end
            if (rvfi_mem_wmask[c*NB+i]) begin
              shadow_next[k][8*i +: 8] = rvfi_mem_wdata[c*XLEN+8*i +: 8];
              written_next[k][i]       = 1'b1;
            end
          end
        end
      end
    end
  end

  // Shadow contents are only meaningful where the written bit is set.
  always_ff @(posedge clock) begin
    for (int k = 0; k < NADDR; k++) begin
      shadow_reg[k] <= shadow_next[k];
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int k = 0; k < NADDR; k++) begin
        written_reg[k] <= '0;
      end
      mismatch   <= 1'b0;
      err_sticky <= 1'b0;
      err_count  <= '0;
      err_chan   <= '0;
      err_slot   <= '0;
      err_byte   <= '0;
    end else begin
      for (int k = 0; k < NADDR; k++) begin
        written_reg[k] <= written_next[k];
      end
      mismatch <= fail_any;
      if (fail_any && (err_count != {CNTW{1'b1}})) begin
        err_count <= err_count + CNTW'(1);
      end
      if (fail_any && !err_sticky) begin
        err_sticky <= 1'b1;
        err_chan   <= cap_chan;
        err_slot   <= cap_slot;
        err_byte   <= cap_byte;
      end
    end
  end

endmodule

// File: tb/tb_rvfi_dmem_multi_check.sv
// Bench for rvfi_dmem_multi_check: directed vector table, corner sequences and
// randomized traffic against a byte-addressed reference memory.
module tb_rvfi_dmem_multi_check;

  localparam int XLEN  = 32;
  localparam int NRET  = 2;
  localparam int NADDR = 4;
  localparam int CNTW  = 4;
  localparam int CMAX  = 15;

  logic                  clock = 1'b0;
  logic                  resetn = 1'b1;
  logic                  enable;
  logic [NADDR*XLEN-1:0] track_addr;
  logic [NRET-1:0]       rvfi_valid;
  logic [NRET*XLEN-1:0]  rvfi_mem_addr;
  logic [NRET*4-1:0]     rvfi_mem_rmask;
  logic [NRET*4-1:0]     rvfi_mem_wmask;
  logic [NRET*XLEN-1:0]  rvfi_mem_rdata;
  logic [NRET*XLEN-1:0]  rvfi_mem_wdata;
  logic                  mismatch;
  logic                  err_sticky;
  logic [CNTW-1:0]       err_count;
  logic [0:0]            err_chan;
  logic [1:0]            err_slot;
  logic [1:0]            err_byte;

  rvfi_dmem_multi_check #(.XLEN(XLEN), .NRET(NRET), .NADDR(NADDR), .CNTW(CNTW)) dut (
    .clock(clock), .resetn(resetn), .enable(enable), .track_addr(track_addr),
    .rvfi_valid(rvfi_valid), .rvfi_mem_addr(rvfi_mem_addr),
    .rvfi_mem_rmask(rvfi_mem_rmask), .rvfi_mem_wmask(rvfi_mem_wmask),
    .rvfi_mem_rdata(rvfi_mem_rdata), .rvfi_mem_wdata(rvfi_mem_wdata),
    .mismatch(mismatch), .err_sticky(err_sticky), .err_count(err_count),
    .err_chan(err_chan), .err_slot(err_slot), .err_byte(err_byte)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  // Slot 2 duplicates slot 0 on purpose.
  logic [31:0] slot_addr [NADDR] = '{32'h100, 32'h200, 32'h100, 32'h300};

  logic        d_en;
  logic [1:0]  d_v;
  logic [31:0] d_a  [2];
  logic [3:0]  d_rm [2];
  logic [3:0]  d_wm [2];
  logic [31:0] d_rd [2];
  logic [31:0] d_wd [2];

  // Reference: one byte memory over tracked addresses; presence means written.
  logic [7:0] m_mem [logic [31:0]];
  int m_mis, m_sticky, m_cnt, m_chan, m_slot, m_lane;

  typedef struct {
    logic        rst;
    logic        en;
    logic [1:0]  v;
    logic [31:0] a0, rd0, wd0, a1, rd1, wd1;
    logic [3:0]  rm0, wm0, rm1, wm1;
    int          e_mis, e_sticky, e_cnt, e_chan, e_slot, e_lane;
  } vec_t;

  vec_t tbl [$];

  function automatic vec_t mk(logic rst, logic en, logic [1:0] v,
                              logic [31:0] a0, logic [3:0] rm0, logic [3:0] wm0,
                              logic [31:0] rd0, logic [31:0] wd0,
                              logic [31:0] a1, logic [3:0] rm1, logic [3:0] wm1,
                              logic [31:0] rd1, logic [31:0] wd1,
                              int mis, int sticky, int cnt, int chan, int slot, int lane);
    vec_t r;
    r.rst = rst; r.en = en; r.v = v;
    r.a0 = a0; r.rm0 = rm0; r.wm0 = wm0; r.rd0 = rd0; r.wd0 = wd0;
    r.a1 = a1; r.rm1 = rm1; r.wm1 = wm1; r.rd1 = rd1; r.wd1 = wd1;
    r.e_mis = mis; r.e_sticky = sticky; r.e_cnt = cnt;
    r.e_chan = chan; r.e_slot = slot; r.e_lane = lane;
    return r;
  endfunction

  task automatic apply_drive();
    enable         = d_en;
    rvfi_valid     = d_v;
    rvfi_mem_addr  = {d_a[1], d_a[0]};
    rvfi_mem_rmask = {d_rm[1], d_rm[0]};
    rvfi_mem_wmask = {d_wm[1], d_wm[0]};
    rvfi_mem_rdata = {d_rd[1], d_rd[0]};
    rvfi_mem_wdata = {d_wd[1], d_wd[0]};
  endtask

  task automatic set_idle();
    d_en = 1'b1;
    d_v  = 2'b00;
    for (int c = 0; c < 2; c++) begin
      d_a[c] = '0; d_rm[c] = '0; d_wm[c] = '0; d_rd[c] = '0; d_wd[c] = '0;
    end
    apply_drive();
  endtask

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(string tag, int mis, int sticky, int cnt, int chan, int slot, int lane);
    $display("%s: mismatch=%0d sticky=%0d count=%0d chan=%0d slot=%0d byte=%0d", tag,
             mismatch, err_sticky, err_count, err_chan, err_slot, err_byte);
    chk({tag, ".mismatch"}, int'(mismatch), mis);
    chk({tag, ".sticky"}, int'(err_sticky), sticky);
    chk({tag, ".count"}, int'(err_count), cnt);
    chk({tag, ".chan"}, int'(err_chan), chan);
    chk({tag, ".slot"}, int'(err_slot), slot);
    chk({tag, ".byte"}, int'(err_byte), lane);
  endtask

  task automatic model_clear();
    m_mem.delete();
    m_mis = 0; m_sticky = 0; m_cnt = 0; m_chan = 0; m_slot = 0; m_lane = 0;
  endtask

  function automatic int first_slot(logic [31:0] word);
    for (int k = 0; k < NADDR; k++) begin
      if ((slot_addr[k] & ~32'h3) == word) return k;
    end
    return -1;
  endfunction

  task automatic model_cycle();
    bit fail = 0;
    bit cap = 0;
    for (int c = 0; c < 2; c++) begin
      if (d_v[c]) begin
        logic [31:0] word = d_a[c] & ~32'h3;
        int k = first_slot(word);
        if (k >= 0) begin
          for (int i = 0; i < 4; i++) begin
            logic [31:0] ba = word + 32'(i);
            if (d_en && d_rm[c][i] && m_mem.exists(ba) && (m_mem[ba] != d_rd[c][8*i +: 8])) begin
              fail = 1;
              if (!m_sticky && !cap) begin
                cap = 1; m_chan = c; m_slot = k; m_lane = i;
              end
            end
            if (d_wm[c][i]) m_mem[ba] = d_wd[c][8*i +: 8];
          end
        end
      end
    end
    m_mis = fail ? 1 : 0;
    if (fail && m_cnt < CMAX) m_cnt++;
    if (cap) m_sticky = 1;
  endtask

  // Asserts reset away from the active edge and checks outputs clear at once.
  task automatic do_reset(string tag);
    @(posedge clock);
    #2 resetn = 1'b0;
    #1 chk_all(tag, 0, 0, 0, 0, 0, 0);
    model_clear();
    set_idle();
    @(negedge clock);
    resetn = 1'b1;
  endtask

  function automatic logic [31:0] pick_addr();
    case ($urandom_range(0, 7))
      0: return 32'h100;
      1: return 32'h101;
      2: return 32'h102;
      3: return 32'h103;
      4: return 32'h200;
      5: return 32'h203;
      6: return 32'h300;
      default: return 32'h400;
    endcase
  endfunction

  initial begin
    track_addr = {slot_addr[3], slot_addr[2], slot_addr[1], slot_addr[0]};
    set_idle();
    model_clear();
    #1 resetn = 1'b0;
    #1 chk_all("reset_state", 0, 0, 0, 0, 0, 0);
    @(negedge clock);
    resetn = 1'b1;

    //          rst en  v     a0      rm0   wm0   rd0           wd0           a1      rm1   wm1   rd1           wd1           mis st cnt ch sl by
    tbl.push_back(mk(1, 1, 2'b01, 32'h100, 4'h0, 4'hF, 32'h0,        32'hAABBCCDD, 32'h0,   4'h0, 4'h0, 32'h0,        32'h0,        0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 2'b01, 32'h100, 4'hF, 4'h0, 32'hAABBCCDD, 32'h0,        32'h0,   4'h0, 4'h0, 32'h0,        32'h0,        0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 2'b01, 32'h102, 4'h4, 4'h0, 32'h00000000, 32'h0,        32'h0,   4'h0, 4'h0, 32'h0,        32'h0,        1, 1, 1, 0, 0, 2));
    tbl.push_back(mk(0, 1, 2'b00, 32'h0,   4'h0, 4'h0, 32'h0,        32'h0,        32'h0,   4'h0, 4'h0, 32'h0,        32'h0,        0, 1, 1, 0, 0, 2));
    tbl.push_back(mk(1, 1, 2'b11, 32'h100, 4'h0, 4'h1, 32'h0,        32'h00000011, 32'h100, 4'h1, 4'h0, 32'h00000011, 32'h0,        0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 2'b11, 32'h100, 4'h0, 4'h1, 32'h0,        32'h00000011, 32'h100, 4'h1, 4'h0, 32'h00000022, 32'h0,        1, 1, 1, 1, 0, 0));
    tbl.push_back(mk(1, 1, 2'b01, 32'h200, 4'hF, 4'h0, 32'hDEADBEEF, 32'h0,        32'h0,   4'h0, 4'h0, 32'h0,        32'h0,        0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 2'b01, 32'h200, 4'h0, 4'h2, 32'h0,        32'h00005500, 32'h0,   4'h0, 4'h0, 32'h0,        32'h0,        0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 2'b01, 32'h200, 4'h2, 4'h2, 32'h00000000, 32'h00006600, 32'h0,   4'h0, 4'h0, 32'h0,        32'h0,        0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 2'b01, 32'h200, 4'h2, 4'h0, 32'h00005500, 32'h0,        32'h0,   4'h0, 4'h0, 32'h0,        32'h0,        1, 1, 1, 0, 1, 1));
    tbl.push_back(mk(0, 1, 2'b11, 32'h103, 4'h0, 4'h8, 32'h0,        32'h77000000, 32'h100, 4'h8, 4'h0, 32'h77000000, 32'h0,        0, 1, 1, 0, 1, 1));
    tbl.push_back(mk(0, 1, 2'b11, 32'h400, 4'h0, 4'hF, 32'h0,        32'h12345678, 32'h400, 4'hF, 4'h0, 32'h0,        32'h0,        0, 1, 1, 0, 1, 1));

    for (int n = 0; n < tbl.size(); n++) begin
      vec_t v = tbl[n];
      if (v.rst) do_reset($sformatf("vec%0d.rst", n));
      d_en = v.en; d_v = v.v;
      d_a[0] = v.a0; d_rm[0] = v.rm0; d_wm[0] = v.wm0; d_rd[0] = v.rd0; d_wd[0] = v.wd0;
      d_a[1] = v.a1; d_rm[1] = v.rm1; d_wm[1] = v.wm1; d_rd[1] = v.rd1; d_wd[1] = v.wd1;
      apply_drive();
      @(negedge clock);
      chk_all($sformatf("vec%0d", n), v.e_mis, v.e_sticky, v.e_cnt, v.e_chan, v.e_slot, v.e_lane);
    end

    // Counter saturation: both channels fail every cycle, first capture must stick.
    do_reset("sat.rst");
    d_v = 2'b01; d_a[0] = 32'h300; d_wm[0] = 4'hF; d_wd[0] = 32'h12345678;
    apply_drive();
    @(negedge clock);
    chk_all("sat.write", 0, 0, 0, 0, 0, 0);
    d_v = 2'b11; d_wm[0] = 4'h0; d_rm[0] = 4'h1; d_rd[0] = 32'h0;
    d_a[1] = 32'h301; d_rm[1] = 4'h2; d_rd[1] = 32'h0;
    apply_drive();
    for (int n = 1; n <= (1 << CNTW) + 3; n++) begin
      @(negedge clock);
      chk_all($sformatf("sat%0d", n), 1, 1, (n < CMAX) ? n : CMAX, 0, 3, 0);
    end

    // Reset in the middle of the failing burst, held across an edge.
    @(posedge clock);
    #2 resetn = 1'b0;
    #1 chk_all("midrst.now", 0, 0, 0, 0, 0, 0);
    @(posedge clock);
    #1 chk_all("midrst.held", 0, 0, 0, 0, 0, 0);
    @(negedge clock);
    resetn = 1'b1;
    d_v = 2'b01; d_rm[0] = 4'hF; d_rd[0] = 32'hFFFFFFFF;
    apply_drive();
    @(negedge clock);
    chk_all("midrst.reread", 0, 0, 0, 0, 0, 0);

    do_reset("rnd.rst");
    for (int n = 0; n < 400; n++) begin
      if (n % 50 == 49) do_reset($sformatf("rnd%0d.rst", n));
      d_en = ($urandom_range(0, 9) != 0);
      d_v  = 2'($urandom_range(0, 3));
      for (int c = 0; c < 2; c++) begin
        d_a[c]  = pick_addr();
        d_rm[c] = 4'($urandom_range(0, 15));
        d_wm[c] = $urandom_range(0, 1) ? 4'($urandom_range(0, 15)) : 4'h0;
        d_wd[c] = $urandom;
        for (int i = 0; i < 4; i++) begin
          logic [31:0] ba = (d_a[c] & ~32'h3) + 32'(i);
          if ($urandom_range(0, 3) != 0 && m_mem.exists(ba)) d_rd[c][8*i +: 8] = m_mem[ba];
          else d_rd[c][8*i +: 8] = 8'($urandom_range(0, 255));
        end
      end
      model_cycle();
      apply_drive();
      @(negedge clock);
      chk_all($sformatf("rnd%0d", n), m_mis, m_sticky, m_cnt, m_chan, m_slot, m_lane);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
